// File: rtl/tone_divider_bank_if.sv
// Control/status bundle for tone_divider_bank: per-channel enables, the shared
// divisor write port, and the per-channel divided clocks, strobes and pending flags.
interface tone_divider_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0] ch_en;
  logic              div_wr;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] outClk;
  logic [NUM_CH-1:0] toggle_pulse;
  logic [NUM_CH-1:0] div_pending;

  modport master (
    output ch_en, div_wr, div_ch, div_data,
    input  outClk, toggle_pulse, div_pending
  );

  modport slave (
    input  ch_en, div_wr, div_ch, div_data,
    output outClk, toggle_pulse, div_pending
  );
endinterface

// File: rtl/tone_divider_bank.sv
// Bank of independent square-wave dividers; each channel reloads its half-period
// terminal count from a shadow register only at a half-period boundary.
module tone_divider_bank #(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = 32,
  parameter int               CH_W        = 2,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(32'hBAB9)
) (
  input  logic          inClk,
  input  logic          reset,
  tone_divider_bank_if.slave bus
);

  logic [CNT_W-1:0]  count_q   [NUM_CH];
  logic [CNT_W-1:0]  count_d   [NUM_CH];
  logic [CNT_W-1:0]  countTo_q [NUM_CH];
  logic [CNT_W-1:0]  countTo_d [NUM_CH];
  logic [CNT_W-1:0]  shadow_q  [NUM_CH];
  logic [CNT_W-1:0]  shadow_d  [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0] wr_hit;

  // A select value at or beyond NUM_CH matches no channel, so the write is dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = bus.div_wr && (bus.div_ch == CH_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      count_d[i]   = count_q[i];
      countTo_d[i] = countTo_q[i];
      shadow_d[i]  = shadow_q[i];
      pending_d[i] = pending_q[i];
      out_d[i]     = out_q[i];
      pulse_d[i]   = 1'b0;

      if (!bus.ch_en[i]) begin
        count_d[i] = '0;
        out_d[i]   = 1'b0;
        if (pending_q[i]) begin
          countTo_d[i] = shadow_q[i];
          pending_d[i] = 1'b0;
        end
      end else if (count_q[i] < countTo_q[i]) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end else begin
        count_d[i] = '0;
        out_d[i]   = ~out_q[i];
        pulse_d[i] = 1'b1;
        if (pending_q[i]) begin
          countTo_d[i] = shadow_q[i];
          pending_d[i] = 1'b0;
        end
      end

      // A write landing on a terminal edge stays pending for the next boundary.
      if (wr_hit[i]) begin
        shadow_d[i]  = bus.div_data;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge inClk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]   <= '0;
        countTo_q[i] <= DEFAULT_DIV;
        shadow_q[i]  <= DEFAULT_DIV;
      end
      pending_q <= '0;
      out_q     <= '0;
      pulse_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]   <= count_d[i];
        countTo_q[i] <= countTo_d[i];
        shadow_q[i]  <= shadow_d[i];
      end
      pending_q <= pending_d;
      out_q     <= out_d;
      pulse_q   <= pulse_d;
    end
  end

  assign bus.outClk       = out_q;
  assign bus.toggle_pulse = pulse_q;
  assign bus.div_pending  = pending_q;

endmodule

// File: tb/tb_tone_divider_bank.sv
// Scoreboard bench: expected toggle cycles are queued as stimulus is applied and
// popped whenever the observed outClk of the channel under test changes.
module tb_tone_divider_bank;
  logic clk = 1'b0;
  logic rst4, rst3;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tone_divider_bank_if #(.NUM_CH(4), .CNT_W(32), .CH_W(2)) b4();
  tone_divider_bank_if #(.NUM_CH(3), .CNT_W(32), .CH_W(2)) b3();

  tone_divider_bank #(.NUM_CH(4), .CNT_W(32), .CH_W(2), .DEFAULT_DIV(32'hBAB9)) dut4 (
    .inClk(clk), .reset(rst4), .bus(b4)
  );
  tone_divider_bank #(.NUM_CH(3), .CNT_W(32), .CH_W(2), .DEFAULT_DIV(32'd9)) dut3 (
    .inClk(clk), .reset(rst3), .bus(b3)
  );

  task automatic test_reset();
    rst4 = 1'b1; rst3 = 1'b1;
    b4.ch_en = '0; b4.div_wr = 1'b1; b4.div_ch = 2'd1; b4.div_data = 32'd7;
    b3.ch_en = '0; b3.div_wr = 1'b0; b3.div_ch = '0;   b3.div_data = '0;
    repeat (3) @(negedge clk);
    total++; if (b4.outClk !== 4'b0) begin bad++; $display("FAIL rst_out4: got %b want 0000", b4.outClk); end
    total++; if (b4.toggle_pulse !== 4'b0) begin bad++; $display("FAIL rst_pulse4: got %b want 0000", b4.toggle_pulse); end
    total++; if (b4.div_pending !== 4'b0) begin bad++; $display("FAIL rst_pend4: got %b want 0000", b4.div_pending); end
    total++; if (b3.outClk !== 3'b0) begin bad++; $display("FAIL rst_out3: got %b want 000", b3.outClk); end
    total++; if (b3.div_pending !== 3'b0) begin bad++; $display("FAIL rst_pend3: got %b want 000", b3.div_pending); end
    rst4 = 1'b0; rst3 = 1'b0; b4.div_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default_div();
    int n; logic p; logic others;
    n = cyc; p = 1'b0; others = 1'b0;
    b4.ch_en = 4'b0001;
    exp_q.delete(); exp_q.push_back(n + 32'hBABA);
    while (cyc < n + 32'hBABA + 4) begin
      @(negedge clk);
      if (b4.outClk[3:1] !== 3'b0) others = 1'b1;
      if (b4.outClk[0] !== p) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL def_extra: got toggle at %0d want none", cyc - n); end
        else begin
          int e; e = exp_q.pop_front();
          if (cyc !== e || b4.outClk[0] !== 1'b1) begin bad++; $display("FAIL def_rise: got %0d/%b want %0d/1", cyc - n, b4.outClk[0], e - n); end
        end
      end
      total++;
      if (b4.toggle_pulse[0] !== (b4.outClk[0] !== p)) begin bad++; $display("FAIL def_pulse: got %b want %b at %0d", b4.toggle_pulse[0], b4.outClk[0] !== p, cyc - n); end
      p = b4.outClk[0];
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL def_timeout: got %0d missing want 0", exp_q.size()); end
    total++; if (others !== 1'b0) begin bad++; $display("FAIL def_others: got %b want 0", others); end
    b4.ch_en = 4'b0000;
    @(negedge clk);
    total++; if (b4.outClk[0] !== 1'b0) begin bad++; $display("FAIL def_disable: got %b want 0", b4.outClk[0]); end
  endtask

  task automatic test_div3();
    int n; logic p;
    b4.div_wr = 1'b1; b4.div_ch = 2'd1; b4.div_data = 32'd3;
    @(negedge clk);
    b4.div_wr = 1'b0;
    total++; if (b4.div_pending !== 4'b0010) begin bad++; $display("FAIL d3_pend_set: got %b want 0010", b4.div_pending); end
    @(negedge clk);
    total++; if (b4.div_pending !== 4'b0000) begin bad++; $display("FAIL d3_pend_clr: got %b want 0000", b4.div_pending); end
    n = cyc; p = 1'b0;
    b4.ch_en = 4'b0010;
    exp_q.delete();
    for (int k = 1; k <= 5; k++) exp_q.push_back(n + 4 * k);
    while (cyc < n + 20) begin
      @(negedge clk);
      if (b4.outClk[1] !== p) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL d3_extra: got toggle at %0d want none", cyc - n); end
        else begin
          int e; e = exp_q.pop_front();
          if (cyc !== e) begin bad++; $display("FAIL d3_toggle: got %0d want %0d", cyc - n, e - n); end
        end
      end
      total++;
      if (b4.toggle_pulse[1] !== (b4.outClk[1] !== p)) begin bad++; $display("FAIL d3_pulse: got %b want %b at %0d", b4.toggle_pulse[1], b4.outClk[1] !== p, cyc - n); end
      p = b4.outClk[1];
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL d3_timeout: got %0d missing want 0", exp_q.size()); end
  endtask

  // Channel 1 is still running at divisor 3 and has just toggled on this edge.
  task automatic test_mid_change();
    int t; logic p;
    t = cyc; p = b4.outClk[1];
    exp_q.delete();
    exp_q.push_back(t + 4); exp_q.push_back(t + 6); exp_q.push_back(t + 8); exp_q.push_back(t + 10);
    while (cyc < t + 11) begin
      @(negedge clk);
      if (b4.outClk[1] !== p) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL mid_extra: got toggle at %0d want none", cyc - t); end
        else begin
          int e; e = exp_q.pop_front();
          if (cyc !== e) begin bad++; $display("FAIL mid_toggle: got %0d want %0d", cyc - t, e - t); end
        end
      end
      total++;
      if (b4.div_pending[1] !== (cyc >= t + 2 && cyc < t + 4)) begin bad++; $display("FAIL mid_pend: got %b want %b at %0d", b4.div_pending[1], (cyc >= t + 2 && cyc < t + 4), cyc - t); end
      p = b4.outClk[1];
      b4.div_wr = (cyc == t + 1);
      b4.div_ch = 2'd1; b4.div_data = 32'd1;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_timeout: got %0d missing want 0", exp_q.size()); end
    b4.ch_en = 4'b0000;
    @(negedge clk);
    total++; if (b4.outClk[1] !== 1'b0) begin bad++; $display("FAIL mid_disable: got %b want 0", b4.outClk[1]); end
  endtask

  task automatic test_terminal_write();
    int n; logic p;
    b4.div_wr = 1'b1; b4.div_ch = 2'd2; b4.div_data = 32'd5;
    @(negedge clk);
    b4.div_wr = 1'b0;
    @(negedge clk);
    n = cyc; p = 1'b0;
    b4.ch_en = 4'b0100;
    exp_q.delete();
    exp_q.push_back(n + 6); exp_q.push_back(n + 12); exp_q.push_back(n + 18);
    exp_q.push_back(n + 19); exp_q.push_back(n + 20); exp_q.push_back(n + 21);
    while (cyc < n + 21) begin
      @(negedge clk);
      if (b4.outClk[2] !== p) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL tw_extra: got toggle at %0d want none", cyc - n); end
        else begin
          int e; e = exp_q.pop_front();
          if (cyc !== e) begin bad++; $display("FAIL tw_toggle: got %0d want %0d", cyc - n, e - n); end
        end
      end
      total++;
      if (b4.toggle_pulse[2] !== (b4.outClk[2] !== p)) begin bad++; $display("FAIL tw_pulse: got %b want %b at %0d", b4.toggle_pulse[2], b4.outClk[2] !== p, cyc - n); end
      total++;
      if (b4.div_pending[2] !== (cyc >= n + 12 && cyc < n + 18)) begin bad++; $display("FAIL tw_pend: got %b want %b at %0d", b4.div_pending[2], (cyc >= n + 12 && cyc < n + 18), cyc - n); end
      p = b4.outClk[2];
      b4.div_wr = (cyc == n + 11);
      b4.div_ch = 2'd2; b4.div_data = 32'd0;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL tw_timeout: got %0d missing want 0", exp_q.size()); end
    b4.ch_en = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_last_write_wins();
    int n; logic p;
    b4.div_wr = 1'b1; b4.div_ch = 2'd3; b4.div_data = 32'd4;
    @(negedge clk);
    b4.div_wr = 1'b0;
    @(negedge clk);
    n = cyc; p = 1'b0;
    b4.ch_en = 4'b1000;
    exp_q.delete();
    exp_q.push_back(n + 5); exp_q.push_back(n + 8); exp_q.push_back(n + 11); exp_q.push_back(n + 14);
    while (cyc < n + 14) begin
      @(negedge clk);
      if (b4.outClk[3] !== p) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL lw_extra: got toggle at %0d want none", cyc - n); end
        else begin
          int e; e = exp_q.pop_front();
          if (cyc !== e) begin bad++; $display("FAIL lw_toggle: got %0d want %0d", cyc - n, e - n); end
        end
      end
      total++;
      if (b4.div_pending[3] !== (cyc >= n + 2 && cyc < n + 5)) begin bad++; $display("FAIL lw_pend: got %b want %b at %0d", b4.div_pending[3], (cyc >= n + 2 && cyc < n + 5), cyc - n); end
      p = b4.outClk[3];
      b4.div_wr = (cyc == n + 1) || (cyc == n + 2);
      b4.div_ch = 2'd3;
      b4.div_data = (cyc == n + 1) ? 32'd7 : 32'd2;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL lw_timeout: got %0d missing want 0", exp_q.size()); end
    b4.ch_en = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int n; int m; logic [2:0] p;
    n = cyc; p = 3'b000;
    b3.ch_en = 3'b111; b3.div_wr = 1'b1; b3.div_ch = 2'd3; b3.div_data = 32'd0;
    exp_q.delete(); exp_q.push_back(n + 10); exp_q.push_back(n + 20);
    while (cyc < n + 21) begin
      @(negedge clk);
      b3.div_wr = 1'b0;
      if (b3.outClk !== p) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL oor_extra: got toggle at %0d want none", cyc - n); end
        else begin
          int e; e = exp_q.pop_front();
          if (cyc !== e || b3.outClk !== ~p) begin bad++; $display("FAIL oor_toggle: got %0d/%b want %0d/%b", cyc - n, b3.outClk, e - n, ~p); end
        end
      end
      total++;
      if (b3.div_pending !== 3'b000) begin bad++; $display("FAIL oor_pend: got %b want 000 at %0d", b3.div_pending, cyc - n); end
      p = b3.outClk;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL oor_timeout: got %0d missing want 0", exp_q.size()); end
    // Reset with a divisor pending on a running channel and a write during reset.
    b3.div_wr = 1'b1; b3.div_ch = 2'd0; b3.div_data = 32'd2;
    @(negedge clk);
    b3.div_wr = 1'b0;
    total++; if (b3.div_pending !== 3'b001) begin bad++; $display("FAIL rst3_pend_set: got %b want 001", b3.div_pending); end
    rst3 = 1'b1; b3.div_wr = 1'b1; b3.div_ch = 2'd1; b3.div_data = 32'd0;
    @(negedge clk);
    rst3 = 1'b0; b3.div_wr = 1'b0;
    total++; if (b3.outClk !== 3'b000) begin bad++; $display("FAIL rst3_out: got %b want 000", b3.outClk); end
    total++; if (b3.div_pending !== 3'b000) begin bad++; $display("FAIL rst3_pend: got %b want 000", b3.div_pending); end
    total++; if (b3.toggle_pulse !== 3'b000) begin bad++; $display("FAIL rst3_pulse: got %b want 000", b3.toggle_pulse); end
    m = cyc; p = 3'b000;
    b3.ch_en = 3'b011;
    exp_q.delete(); exp_q.push_back(m + 10);
    while (cyc < m + 12) begin
      @(negedge clk);
      if (b3.outClk !== p) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rst3_extra: got toggle at %0d want none", cyc - m); end
        else begin
          int e; e = exp_q.pop_front();
          if (cyc !== e || b3.outClk !== 3'b011) begin bad++; $display("FAIL rst3_toggle: got %0d/%b want %0d/011", cyc - m, b3.outClk, e - m); end
        end
      end
      total++;
      if (b3.div_pending !== 3'b000) begin bad++; $display("FAIL rst3_pend_run: got %b want 000 at %0d", b3.div_pending, cyc - m); end
      p = b3.outClk;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rst3_timeout: got %0d missing want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic moved;
    b4.ch_en = 4'b1111;
    repeat (5) @(negedge clk);
    b4.div_wr = 1'b1; b4.div_ch = 2'd0; b4.div_data = 32'd3;
    @(negedge clk);
    b4.div_wr = 1'b0;
    total++; if (b4.div_pending[0] !== 1'b1) begin bad++; $display("FAIL rm_pend_set: got %b want 1", b4.div_pending[0]); end
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    total++; if (b4.outClk !== 4'b0) begin bad++; $display("FAIL rm_out: got %b want 0000", b4.outClk); end
    total++; if (b4.div_pending !== 4'b0) begin bad++; $display("FAIL rm_pend: got %b want 0000", b4.div_pending); end
    total++; if (b4.toggle_pulse !== 4'b0) begin bad++; $display("FAIL rm_pulse: got %b want 0000", b4.toggle_pulse); end
    // Every channel is back at the long default divisor, so nothing may toggle soon.
    moved = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (b4.outClk !== 4'b0) moved = 1'b1;
    end
    total++; if (moved !== 1'b0) begin bad++; $display("FAIL rm_default: got early toggle want none"); end
    b4.ch_en = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_div3();
    test_mid_change();
    test_terminal_write();
    test_last_write_wins();
    test_out_of_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
